// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared constants and state encoding for the boot-time instruction ROM loader
package inst_rom_loader_pkg;

    // Reset polarity of the openmips core
    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    // Instruction word width and default instruction memory depth (log2, in words)
    localparam int INST_BUS_W        = 32;
    localparam int INST_MEM_NUM_LOG2 = 17;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// inst_rom_loader_byte_packer: assembles big-endian 32-bit words from a byte stream
//   clk, rst      : clock, asynchronous active-low reset
//   en            : a byte is accepted this cycle
//   byte_in       : the accepted byte
//   word          : current word with byte_in as its least significant byte
//   word_done     : en on the 4th byte of a word; word is complete this cycle
module inst_rom_loader_byte_packer
    import inst_rom_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            byte_in,
    output logic [INST_BUS_W-1:0] word,
    output logic                  word_done
);

    logic [INST_BUS_W-9:0] sr;
    logic [1:0]            cnt;

    assign word      = {sr, byte_in};
    assign word_done = en && cnt == 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (en) begin
            sr  <= {sr[INST_BUS_W-17:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: loads a framed byte stream into instruction memory and releases the CPU on a good checksum
//   clk, rst      : clock, asynchronous active-low reset
//   rx_data/valid : incoming byte stream; rx_ready accepts a byte on valid && ready
//   mem_we_o      : one-cycle write strobe per word, with mem_waddr_o / mem_wdata_o
//   cpu_rst_o     : active-high core reset, released the cycle after a verified load
//   done_o        : image loaded and verified
//   err_o         : frame rejected (oversize, bad checksum or timeout), sticky
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W  = INST_MEM_NUM_LOG2,
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_waddr_o,
    output logic [INST_BUS_W-1:0] mem_wdata_o,
    output logic                  cpu_rst_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    // Largest accepted word count, one bit wider than the length so 2**ADDR_W is representable
    localparam logic [CNT_W:0] MAX_WORDS = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    state_t                state;
    logic [1:0]            len_cnt;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      word_idx;
    logic [7:0]            xsum;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  accept;
    logic                  armed;
    logic                  timeout;
    logic [CNT_W-1:0]      new_len;
    logic [INST_BUS_W-1:0] word;
    logic                  word_done;

    assign accept  = rx_valid && rx_ready;
    assign new_len = {len[CNT_W-9:0], rx_data};
    // The idle timer only runs once a frame has started
    assign armed   = (state == S_LEN && len_cnt != 2'd0) || state == S_DATA || state == S_CSUM;
    assign timeout = armed && !accept && idle_cnt == IDLE_W'(TIMEOUT - 1);

    inst_rom_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .en        (accept && state == S_DATA),
        .byte_in   (rx_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_LEN;
            len_cnt     <= '0;
            len         <= '0;
            word_idx    <= '0;
            xsum        <= '0;
            idle_cnt    <= '0;
            rx_ready    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
            cpu_rst_o   <= RST_ENABLE;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            rx_ready <= state inside {S_LEN, S_DATA, S_CSUM};
            idle_cnt <= accept ? '0 : armed ? idle_cnt + 1'b1 : '0;
            if (accept && state != S_CSUM)
                xsum <= xsum ^ rx_data;
            if (timeout) begin
                state    <= S_ERR;
                rx_ready <= 1'b0;
                err_o    <= 1'b1;
            end else begin
                case (state)
                    S_LEN: if (accept) begin
                        len     <= new_len;
                        len_cnt <= len_cnt + 2'd1;
                        if (len_cnt == 2'd3) begin
                            if ({1'b0, new_len} > MAX_WORDS) begin
                                state    <= S_ERR;
                                rx_ready <= 1'b0;
                                err_o    <= 1'b1;
                            end else begin
                                state <= new_len == '0 ? S_CSUM : S_DATA;
                            end
                        end
                    end
                    S_DATA: if (word_done) begin
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= word;
                        mem_waddr_o <= word_idx[ADDR_W-1:0];
                        word_idx    <= word_idx + 1'b1;
                        if (word_idx == len - 1'b1)
                            state <= S_CSUM;
                    end
                    S_CSUM: if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == xsum) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end
                    end
                    S_DONE: cpu_rst_o <= RST_DISABLE;
                    default: ;
                endcase
            end
        end
    end

endmodule
